// File: rtl/rr_encoder_8.sv
// Purpose  : round-robin 8-to-3 encoder; picks one requester and holds its index/one-hot grant until accepted.
// Latency  : 1 cycle from req to out_valid; all outputs registered, no comb path from req/out_ready.
// Backpress: while out_valid && !out_ready every output is frozen and req is ignored.
//
// Ports:
//   clock, ctrl_reset_n        - sole clock, async active-low reset
//   req[7:0]                   - request levels, sampled every rising edge
//   out_ready                  - consumer accepts the presented grant
//   out_valid/out_index/
//   out_onehot/out_multi       - registered grant; multi = >1 request when captured
//   RR_ENABLE (param)          - 1: rotate priority after each accept; 0: fixed, index 0 highest
module rr_encoder_8 #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clock,
    input  logic       ctrl_reset_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_index,
    output logic [7:0] out_onehot,
    output logic       out_multi
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] onehot_q, onehot_d;
    logic       multi_q, multi_d;

    logic       handshake;
    logic [2:0] base;
    logic [15:0] dbl;
    logic [2:0] off;
    logic [2:0] winner;
    logic       req_any;
    logic       req_multi;

    assign handshake = (state_q == HOLD) && out_ready;
    assign req_any   = |req;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign req_multi = |(req & (req - 8'd1));

    // Search base: after an accept the just-granted index drops to last place.
    always_comb begin
        base = ptr_q;
        if (!RR_ENABLE) begin
            base = 3'd0;
        end else if (handshake) begin
            base = 3'(idx_q + 3'd1);
        end
    end

    // Rotate req so the base lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        dbl = {req, req} >> base;
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (dbl[i]) begin
                off = 3'(i);
            end
        end
        winner = 3'(base + off);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        multi_d  = multi_q;
        case (state_q)
            EMPTY: begin
                if (req_any) begin
                    state_d  = HOLD;
                    idx_d    = winner;
                    onehot_d = 8'd1 << winner;
                    multi_d  = req_multi;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ptr_d = RR_ENABLE ? 3'(idx_q + 3'd1) : 3'd0;
                    if (req_any) begin
                        idx_d    = winner;
                        onehot_d = 8'd1 << winner;
                        multi_d  = req_multi;
                    end else begin
                        state_d  = EMPTY;
                        idx_d    = 3'd0;
                        onehot_d = 8'h00;
                        multi_d  = 1'b0;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q  <= EMPTY;
            ptr_q    <= 3'd0;
            idx_q    <= 3'd0;
            onehot_q <= 8'h00;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            multi_q  <= multi_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_index  = idx_q;
    assign out_onehot = onehot_q;
    assign out_multi  = multi_q;

endmodule

// File: tb/tb_rr_encoder_8.sv
// Purpose  : self-checking bench for rr_encoder_8 (round-robin and fixed-priority instances side by side).
// Latency  : compares registered outputs 1 ns after each rising edge.
// Backpress: out_ready driven from vectors, hand sequences and $urandom.
module tb_rr_encoder_8;

    logic       clock = 1'b0;
    logic       ctrl_reset_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;

    logic       dv [2];
    logic [2:0] di [2];
    logic [7:0] dh [2];
    logic       dm [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Instance 0: round robin; instance 1: fixed priority.
    rr_encoder_8 #(.RR_ENABLE(1'b1)) u_rr (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .req(req), .out_ready(out_ready),
        .out_valid(dv[0]), .out_index(di[0]), .out_onehot(dh[0]), .out_multi(dm[0])
    );
    rr_encoder_8 #(.RR_ENABLE(1'b0)) u_fix (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .req(req), .out_ready(out_ready),
        .out_valid(dv[1]), .out_index(di[1]), .out_onehot(dh[1]), .out_multi(dm[1])
    );

    // Reference model: grant holder plus the index that has highest priority next.
    bit       m_v     [2];
    int       m_idx   [2];
    bit       m_multi [2];
    int       m_ptr   [2];

    function automatic int pick(input bit [7:0] r, input int first);
        for (int k = 0; k < 8; k++) begin
            if (r[(first + k) % 8]) return (first + k) % 8;
        end
        return -1;
    endfunction

    function automatic int popc(input bit [7:0] r);
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(r[k]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 0; m_idx[i] = 0; m_multi[i] = 0; m_ptr[i] = 0;
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit rr = (i == 0);
            bit load = 0;
            if (m_v[i] && out_ready) begin
                m_ptr[i] = rr ? (m_idx[i] + 1) % 8 : 0;
                if (req != 0) load = 1;
                else begin
                    m_v[i] = 0; m_idx[i] = 0; m_multi[i] = 0;
                end
            end else if (!m_v[i] && req != 0) begin
                load = 1;
            end
            if (load) begin
                m_v[i]     = 1;
                m_idx[i]   = pick(req, rr ? m_ptr[i] : 0);
                m_multi[i] = popc(req) > 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] exp_oh;
            exp_oh = m_v[i] ? (8'd1 << m_idx[i]) : 8'h00;
            chk($sformatf("%s[%0d].valid", tag, i), 32'(dv[i]), 32'(m_v[i]));
            chk($sformatf("%s[%0d].index", tag, i), 32'(di[i]), 32'(m_idx[i]));
            chk($sformatf("%s[%0d].onehot", tag, i), 32'(dh[i]), 32'(exp_oh));
            chk($sformatf("%s[%0d].multi", tag, i), 32'(dm[i]), 32'(m_multi[i]));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        chk_model(tag);
    endtask

    task automatic do_reset();
        ctrl_reset_n = 1'b0;
        req = 8'h00;
        out_ready = 1'b0;
        model_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        ctrl_reset_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [2:0] idx;
        logic       multi;
    } vec_t;

    vec_t vt [14];

    initial begin
        // Hand-derived expectations for the round-robin instance, starting from reset.
        vt[0]  = '{8'h20, 1'b1, 1'b1, 3'd5, 1'b0}; // single request
        vt[1]  = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0}; // accept, nothing left, ptr=6
        vt[2]  = '{8'h03, 1'b1, 1'b1, 3'd0, 1'b1}; // base 6 wraps to 0
        vt[3]  = '{8'h03, 1'b1, 1'b1, 3'd1, 1'b1};
        vt[4]  = '{8'h03, 1'b1, 1'b1, 3'd0, 1'b1}; // wrap again
        vt[5]  = '{8'h81, 1'b0, 1'b1, 3'd0, 1'b1}; // frozen
        vt[6]  = '{8'h02, 1'b0, 1'b1, 3'd0, 1'b1}; // frozen though granted bit dropped
        vt[7]  = '{8'h02, 1'b1, 1'b1, 3'd1, 1'b0};
        vt[8]  = '{8'h80, 1'b1, 1'b1, 3'd7, 1'b0};
        vt[9]  = '{8'h80, 1'b0, 1'b1, 3'd7, 1'b0};
        vt[10] = '{8'h81, 1'b1, 1'b1, 3'd0, 1'b1}; // index 7 accepted -> ptr 0
        vt[11] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0}; // ptr=1
        vt[12] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0}; // ready while empty: no effect
        vt[13] = '{8'h06, 1'b0, 1'b1, 3'd1, 1'b1}; // capture from EMPTY ignores ready

        do_reset();
        chk("reset.valid", 32'(dv[0]), 32'd0);
        chk("reset.index", 32'(di[0]), 32'd0);
        chk("reset.onehot", 32'(dh[0]), 32'd0);
        chk("reset.multi", 32'(dm[0]), 32'd0);

        for (int n = 0; n < 14; n++) begin
            req = vt[n].req;
            out_ready = vt[n].rdy;
            step($sformatf("vec%0d", n));
            chk($sformatf("vec%0d.valid", n), 32'(dv[0]), 32'(vt[n].v));
            chk($sformatf("vec%0d.index", n), 32'(di[0]), 32'(vt[n].idx));
            chk($sformatf("vec%0d.multi", n), 32'(dm[0]), 32'(vt[n].multi));
            chk($sformatf("vec%0d.onehot", n), 32'(dh[0]),
                vt[n].v ? 32'(8'd1 << vt[n].idx) : 32'd0);
        end

        // Round robin over all eight requesters, then wrap to 0.
        do_reset();
        req = 8'hFF;
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            step($sformatf("rr%0d", n));
            chk($sformatf("rr%0d.index", n), 32'(di[0]), 32'(n % 8));
            chk($sformatf("rr%0d.multi", n), 32'(dm[0]), 32'd1);
            chk($sformatf("fix%0d.index", n), 32'(di[1]), 32'd0);
        end
        req = 8'hC0;
        step("fixC0a");
        step("fixC0b");
        chk("fixC0.index", 32'(di[1]), 32'd6);
        step("fixC0c");
        chk("fixC0c.index", 32'(di[1]), 32'd6);

        // Asynchronous reset while holding a grant.
        req = 8'hFF;
        out_ready = 1'b0;
        step("prehold");
        chk("prehold.valid", 32'(dv[0]), 32'd1);
        @(negedge clock);
        ctrl_reset_n = 1'b0;
        #1;
        model_reset();
        chk("async.valid", 32'(dv[0]), 32'd0);
        chk("async.index", 32'(di[0]), 32'd0);
        chk("async.onehot", 32'(dh[0]), 32'd0);
        chk("async.multi", 32'(dm[0]), 32'd0);
        chk("async.valid_fix", 32'(dv[1]), 32'd0);
        @(posedge clock); #1;
        req = 8'h00;
        ctrl_reset_n = 1'b1;
        step("postrst0");
        step("postrst1");
        chk("postrst.valid", 32'(dv[0]), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(3))
                0: req = 8'h00;
                1: req = 8'(1 << $urandom_range(7));
                default: req = 8'($urandom);
            endcase
            out_ready = ($urandom_range(3) != 0);
            step($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
